// File: rtl/mips_alu_pkg.sv
// Shared definitions for the MIPS ALU issue sequencer: ALU control codes,
// opcode/funct encodings, FSM state and branch-kind enums and the decode bundle.
package mips_alu_pkg;

  // ALU control codes understood by mips_alu
  localparam logic [3:0] AluAnd = 4'd0;
  localparam logic [3:0] AluOr  = 4'd1;
  localparam logic [3:0] AluAdd = 4'd2;
  localparam logic [3:0] AluSub = 4'd6;
  localparam logic [3:0] AluSlt = 4'd7;  // unsigned compare
  localparam logic [3:0] AluSll = 4'd10;
  localparam logic [3:0] AluSrl = 4'd11;
  localparam logic [3:0] AluNor = 4'd12;

  // Primary opcodes
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpSlti  = 6'h0a;
  localparam logic [5:0] OpSltiu = 6'h0b;
  localparam logic [5:0] OpAndi  = 6'h0c;
  localparam logic [5:0] OpOri   = 6'h0d;

  // R-type funct field
  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnSlt  = 6'h2a;
  localparam logic [5:0] FnSltu = 6'h2b;

  // Flipping bit 31 turns a signed compare into an unsigned one
  localparam logic [31:0] SignBias = 32'h8000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  typedef enum logic [1:0] {
    BrNone,
    BrEq,
    BrNe
  } br_kind_e;

  // Everything the sequencer needs from one decoded instruction
  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [4:0]  wr_reg;
    logic        wr_en;
    br_kind_e    br_kind;
    logic        illegal;
    logic        ovf_chk;
  } dec_t;

  // Signed overflow from operand and result sign bits (b is the subtrahend when is_sub)
  function automatic logic signed_ovf(input logic is_sub, input logic a_msb,
                                      input logic b_msb, input logic r_msb);
    logic same_sign;
    same_sign = is_sub ? (a_msb != b_msb) : (a_msb == b_msb);
    return same_sign && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/mips_alu_issue_if.sv
// Bundles the instruction handshake, the ALU port pair and the response
// handshake of the issue sequencer. The sequencer uses the slave view; the
// surrounding datapath (register read, ALU, write-back) uses the master view.
interface mips_alu_issue_if;

  // Instruction request
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  // ALU ports
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_out;
  logic        alu_zero;

  // Write-back / branch response
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_wr_reg;
  logic        res_wr_en;
  logic        res_branch_taken;
  logic        res_illegal;
  logic        res_ovf;

  modport master (
    output in_valid, instr, rs_val, rt_val, alu_out, alu_zero, res_ready,
    input  in_ready, alu_ctrl, alu_a, alu_b, alu_shamt,
    input  res_valid, res_data, res_wr_reg, res_wr_en, res_branch_taken, res_illegal, res_ovf
  );

  modport slave (
    input  in_valid, instr, rs_val, rt_val, alu_out, alu_zero, res_ready,
    output in_ready, alu_ctrl, alu_a, alu_b, alu_shamt,
    output res_valid, res_data, res_wr_reg, res_wr_en, res_branch_taken, res_illegal, res_ovf
  );

endinterface

// File: rtl/mips_alu_decode.sv
// Combinational decoder: maps a MIPS instruction and its register operands to
// ALU control/operands/shift amount plus write-back, branch and illegal info.
module mips_alu_decode
  import mips_alu_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [31:0] i_rs_val,
  input  logic [31:0] i_rt_val,
  output dec_t        o_dec
);

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [31:0] w_imm_sext;
  logic [31:0] w_imm_zext;
  logic        w_legal;
  logic        w_writes;
  logic [4:0]  w_dst;
  logic        w_unused_rs_field;

  assign w_opcode   = i_instr[31:26];
  assign w_rt       = i_instr[20:16];
  assign w_rd       = i_instr[15:11];
  assign w_shamt    = i_instr[10:6];
  assign w_funct    = i_instr[5:0];
  assign w_imm_sext = {{16{i_instr[15]}}, i_instr[15:0]};
  assign w_imm_zext = {16'h0000, i_instr[15:0]};

  // rs arrives already resolved as i_rs_val
  assign w_unused_rs_field = ^i_instr[25:21];

  // Decode opcode/funct into the ALU issue bundle
  always_comb begin
    o_dec.ctrl    = AluAnd;
    o_dec.a       = i_rs_val;
    o_dec.b       = i_rt_val;
    o_dec.shamt   = 5'd0;
    o_dec.wr_reg  = 5'd0;
    o_dec.wr_en   = 1'b0;
    o_dec.br_kind = BrNone;
    o_dec.illegal = 1'b0;
    o_dec.ovf_chk = 1'b0;
    w_legal       = 1'b1;
    w_writes      = 1'b1;
    w_dst         = w_rt;

    if (w_opcode == OpRtype) begin
      w_dst = w_rd;
      case (w_funct)
        FnAdd: begin
          o_dec.ctrl    = AluAdd;
          o_dec.ovf_chk = 1'b1;
        end
        FnAddu: o_dec.ctrl = AluAdd;
        FnSub: begin
          o_dec.ctrl    = AluSub;
          o_dec.ovf_chk = 1'b1;
        end
        FnSubu: o_dec.ctrl = AluSub;
        FnAnd:  o_dec.ctrl = AluAnd;
        FnOr:   o_dec.ctrl = AluOr;
        FnNor:  o_dec.ctrl = AluNor;
        FnSltu: o_dec.ctrl = AluSlt;
        FnSlt: begin
          o_dec.ctrl = AluSlt;
          o_dec.a    = i_rs_val ^ SignBias;
          o_dec.b    = i_rt_val ^ SignBias;
        end
        FnSll: begin
          o_dec.ctrl  = AluSll;
          o_dec.a     = 32'd0;
          o_dec.shamt = w_shamt;
        end
        FnSrl: begin
          o_dec.ctrl  = AluSrl;
          o_dec.a     = 32'd0;
          o_dec.shamt = w_shamt;
        end
        default: w_legal = 1'b0;
      endcase
    end else begin
      o_dec.b = w_imm_sext;
      case (w_opcode)
        OpAddi: begin
          o_dec.ctrl    = AluAdd;
          o_dec.ovf_chk = 1'b1;
        end
        OpAddiu: o_dec.ctrl = AluAdd;
        OpSlti: begin
          o_dec.ctrl = AluSlt;
          o_dec.a    = i_rs_val ^ SignBias;
          o_dec.b    = w_imm_sext ^ SignBias;
        end
        OpSltiu: o_dec.ctrl = AluSlt;
        OpAndi: begin
          o_dec.ctrl = AluAnd;
          o_dec.b    = w_imm_zext;
        end
        OpOri: begin
          o_dec.ctrl = AluOr;
          o_dec.b    = w_imm_zext;
        end
        OpBeq: begin
          o_dec.ctrl    = AluSub;
          o_dec.b       = i_rt_val;
          o_dec.br_kind = BrEq;
          w_writes      = 1'b0;
        end
        OpBne: begin
          o_dec.ctrl    = AluSub;
          o_dec.b       = i_rt_val;
          o_dec.br_kind = BrNe;
          w_writes      = 1'b0;
        end
        default: w_legal = 1'b0;
      endcase
    end

    if (!w_legal) begin
      // Illegal: nothing is issued, only the flag survives
      o_dec.ctrl    = AluAnd;
      o_dec.a       = 32'd0;
      o_dec.b       = 32'd0;
      o_dec.shamt   = 5'd0;
      o_dec.br_kind = BrNone;
      o_dec.ovf_chk = 1'b0;
      o_dec.illegal = 1'b1;
    end else begin
      o_dec.wr_reg = w_dst;
      // $zero is never written
      o_dec.wr_en  = w_writes && (w_dst != 5'd0);
    end
  end

endmodule

// File: rtl/mips_alu_issue.sv
// Multi-cycle issue sequencer between register-read and write-back. Accepts an
// instruction, issues it to the external combinational ALU for one cycle,
// captures the result and returns a write-back/branch response.
// Optional feature: define MIPS_ALU_ISSUE_OVF_EN to flag signed overflow on
// add/addi/sub and suppress their write-back; otherwise res_ovf is tied 0.
module mips_alu_issue
  import mips_alu_pkg::*;
(
  input logic             clk,
  input logic             rst,
  mips_alu_issue_if.slave bus
);

  state_e      r_state;
  state_e      w_state_next;
  logic        w_accept;
  dec_t        w_dec;

  logic [3:0]  r_alu_ctrl;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [4:0]  r_alu_shamt;

  logic [31:0] r_res_data;
  logic [4:0]  r_res_wr_reg;
  logic        r_res_wr_en;
  logic        r_res_taken;
  logic        r_res_illegal;
  br_kind_e    r_br_kind;
  logic        w_taken;

  mips_alu_decode u_decode (
    .i_instr  (bus.instr),
    .i_rs_val (bus.rs_val),
    .i_rt_val (bus.rt_val),
    .o_dec    (w_dec)
  );

`ifdef MIPS_ALU_ISSUE_OVF_EN
  logic r_ovf_chk;
  logic r_res_ovf;
  logic w_ovf;

  // Overflow of the instruction currently on the ALU ports
  always_comb begin
    w_ovf = r_ovf_chk && signed_ovf(r_alu_ctrl == AluSub, r_alu_a[31], r_alu_b[31],
                                    bus.alu_out[31]);
  end

  assign bus.res_ovf = r_res_ovf;
`else
  logic w_unused_ovf_chk;

  assign w_unused_ovf_chk = w_dec.ovf_chk;
  assign bus.res_ovf      = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; illegal instructions skip the ALU cycle
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      StIdle: begin
        if (bus.in_valid && !rst) begin
          w_accept     = 1'b1;
          w_state_next = w_dec.illegal ? StResp : StExec;
        end
      end
      StExec:  w_state_next = StResp;
      StResp: begin
        if (bus.res_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Branch outcome from the ALU zero flag of the subtract
  always_comb begin
    case (r_br_kind)
      BrEq:    w_taken = bus.alu_zero;
      BrNe:    w_taken = !bus.alu_zero;
      default: w_taken = 1'b0;
    endcase
  end

  // ALU port and response registers: load on accept, capture result in EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_ctrl    <= 4'd0;
      r_alu_a       <= 32'd0;
      r_alu_b       <= 32'd0;
      r_alu_shamt   <= 5'd0;
      r_res_data    <= 32'd0;
      r_res_wr_reg  <= 5'd0;
      r_res_wr_en   <= 1'b0;
      r_res_taken   <= 1'b0;
      r_res_illegal <= 1'b0;
      r_br_kind     <= BrNone;
`ifdef MIPS_ALU_ISSUE_OVF_EN
      r_ovf_chk     <= 1'b0;
      r_res_ovf     <= 1'b0;
`endif
    end else if (w_accept) begin
      r_alu_ctrl    <= w_dec.ctrl;
      r_alu_a       <= w_dec.a;
      r_alu_b       <= w_dec.b;
      r_alu_shamt   <= w_dec.shamt;
      r_res_data    <= 32'd0;
      r_res_wr_reg  <= w_dec.wr_reg;
      r_res_wr_en   <= w_dec.wr_en;
      r_res_taken   <= 1'b0;
      r_res_illegal <= w_dec.illegal;
      r_br_kind     <= w_dec.br_kind;
`ifdef MIPS_ALU_ISSUE_OVF_EN
      r_ovf_chk     <= w_dec.ovf_chk;
      r_res_ovf     <= 1'b0;
`endif
    end else if (r_state == StExec) begin
      r_res_data  <= bus.alu_out;
      r_res_taken <= w_taken;
`ifdef MIPS_ALU_ISSUE_OVF_EN
      if (w_ovf) begin
        // Wrapped result is kept in res_data but never written back
        r_res_ovf   <= 1'b1;
        r_res_wr_en <= 1'b0;
      end
`endif
    end
  end

  assign bus.in_ready         = (r_state == StIdle) && !rst;
  assign bus.res_valid        = (r_state == StResp);
  assign bus.alu_ctrl         = r_alu_ctrl;
  assign bus.alu_a            = r_alu_a;
  assign bus.alu_b            = r_alu_b;
  assign bus.alu_shamt        = r_alu_shamt;
  assign bus.res_data         = r_res_data;
  assign bus.res_wr_reg       = r_res_wr_reg;
  assign bus.res_wr_en        = r_res_wr_en;
  assign bus.res_branch_taken = r_res_taken;
  assign bus.res_illegal      = r_res_illegal;

endmodule

// File: tb/tb_mips_alu_issue.sv
// Self-checking bench for mips_alu_issue: behavioural ALU on the ALU ports,
// instruction-level reference model feeding a scoreboard queue.
module tb_mips_alu_issue;

`ifdef MIPS_ALU_ISSUE_OVF_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  wr_reg;
    logic        wr_en;
    logic        taken;
    logic        illegal;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  time  last_acc = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mips_alu_issue_if bus ();

  mips_alu_issue u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural mips_alu
  always_comb begin
    case (bus.alu_ctrl)
      4'd0:    bus.alu_out = bus.alu_a & bus.alu_b;
      4'd1:    bus.alu_out = bus.alu_a | bus.alu_b;
      4'd2:    bus.alu_out = bus.alu_a + bus.alu_b;
      4'd6:    bus.alu_out = bus.alu_a - bus.alu_b;
      4'd7:    bus.alu_out = (bus.alu_a < bus.alu_b) ? 32'd1 : 32'd0;
      4'd10:   bus.alu_out = bus.alu_b << bus.alu_shamt;
      4'd11:   bus.alu_out = bus.alu_b >> bus.alu_shamt;
      4'd12:   bus.alu_out = ~(bus.alu_a | bus.alu_b);
      default: bus.alu_out = 32'd0;
    endcase
    bus.alu_zero = (bus.alu_out == 32'd0);
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Architectural result of one instruction
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs,
                                 input logic [31:0] rt);
    exp_t        e;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  dst;
    logic [31:0] sx;
    logic [31:0] zx;
    logic        legal;
    logic        wr;
    logic        ovf;
    longint      s;
    op    = ins[31:26];
    fn    = ins[5:0];
    sx    = {{16{ins[15]}}, ins[15:0]};
    zx    = {16'h0000, ins[15:0]};
    e     = '0;
    legal = 1'b1;
    wr    = 1'b1;
    ovf   = 1'b0;
    dst   = ins[20:16];
    if (op == 6'h00) begin
      dst = ins[15:11];
      case (fn)
        6'h20: begin
          e.data = rs + rt;
          s      = longint'($signed(rs)) + longint'($signed(rt));
          ovf    = (s != longint'($signed(e.data)));
        end
        6'h21: e.data = rs + rt;
        6'h22: begin
          e.data = rs - rt;
          s      = longint'($signed(rs)) - longint'($signed(rt));
          ovf    = (s != longint'($signed(e.data)));
        end
        6'h23: e.data = rs - rt;
        6'h24: e.data = rs & rt;
        6'h25: e.data = rs | rt;
        6'h27: e.data = ~(rs | rt);
        6'h2a: e.data = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
        6'h2b: e.data = (rs < rt) ? 32'd1 : 32'd0;
        6'h00: e.data = rt << ins[10:6];
        6'h02: e.data = rt >> ins[10:6];
        default: legal = 1'b0;
      endcase
    end else begin
      case (op)
        6'h08: begin
          e.data = rs + sx;
          s      = longint'($signed(rs)) + longint'($signed(sx));
          ovf    = (s != longint'($signed(e.data)));
        end
        6'h09: e.data = rs + sx;
        6'h0a: e.data = ($signed(rs) < $signed(sx)) ? 32'd1 : 32'd0;
        6'h0b: e.data = (rs < sx) ? 32'd1 : 32'd0;
        6'h0c: e.data = rs & zx;
        6'h0d: e.data = rs | zx;
        6'h04: begin
          e.data  = rs - rt;
          e.taken = (rs == rt);
          wr      = 1'b0;
        end
        6'h05: begin
          e.data  = rs - rt;
          e.taken = (rs != rt);
          wr      = 1'b0;
        end
        default: legal = 1'b0;
      endcase
    end
    if (!legal) begin
      e         = '0;
      e.illegal = 1'b1;
    end else begin
      e.ovf    = OvfEn && ovf;
      e.wr_reg = dst;
      e.wr_en  = wr && (dst != 5'd0) && !e.ovf;
    end
    return e;
  endfunction

  // Offer one instruction and wait for its handshake; returns #1 after the accept edge
  task automatic send(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    int n;
    n = 0;
    sb_q.push_back(model(ins, rs, rt));
    bus.instr    = ins;
    bus.rs_val   = rs;
    bus.rt_val   = rt;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: in_ready=%b required 1 (instr %h)", bus.in_ready, ins);
    end
    @(posedge clk);
    last_acc = $time;
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Wait for the response, check latency and fields against the scoreboard, then consume it
  task automatic recv(input int lat, input string name);
    int   n;
    exp_t e;
    n = 0;
    while (!bus.res_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (bus.res_valid !== 1'b1 || n != lat) begin
      errors++;
      $display("FAIL %s latency: res_valid=%b after %0d edges, required 1 after %0d",
               name, bus.res_valid, n, lat);
    end
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty queue, required an entry", name);
    end else begin
      e = sb_q.pop_front();
      checks++;
      if (bus.res_data !== e.data) begin
        errors++;
        $display("FAIL %s data: got %h required %h", name, bus.res_data, e.data);
      end
      checks++;
      if (bus.res_wr_reg !== e.wr_reg || bus.res_wr_en !== e.wr_en) begin
        errors++;
        $display("FAIL %s wb: got reg=%0d en=%b required reg=%0d en=%b", name,
                 bus.res_wr_reg, bus.res_wr_en, e.wr_reg, e.wr_en);
      end
      checks++;
      if (bus.res_branch_taken !== e.taken || bus.res_illegal !== e.illegal ||
          bus.res_ovf !== e.ovf) begin
        errors++;
        $display("FAIL %s flags: got taken=%b ill=%b ovf=%b required taken=%b ill=%b ovf=%b",
                 name, bus.res_branch_taken, bus.res_illegal, bus.res_ovf, e.taken,
                 e.illegal, e.ovf);
      end
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: got res_valid=%b in_ready=%b required 0 1", name,
               bus.res_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b0;
    bus.instr     = 32'd0;
    bus.rs_val    = 32'd0;
    bus.rt_val    = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: got in_ready=%b res_valid=%b required 0 0", bus.in_ready,
               bus.res_valid);
    end
    checks++;
    if ({bus.alu_ctrl, bus.alu_a, bus.alu_b, bus.alu_shamt} !== 73'd0) begin
      errors++;
      $display("FAIL reset_alu: got ctrl=%h a=%h b=%h sh=%h required all 0", bus.alu_ctrl,
               bus.alu_a, bus.alu_b, bus.alu_shamt);
    end
    checks++;
    if ({bus.res_data, bus.res_wr_reg, bus.res_wr_en, bus.res_branch_taken, bus.res_illegal,
         bus.res_ovf} !== 41'd0) begin
      errors++;
      $display("FAIL reset_res: got data=%h reg=%0d en=%b tk=%b ill=%b ovf=%b required all 0",
               bus.res_data, bus.res_wr_reg, bus.res_wr_en, bus.res_branch_taken,
               bus.res_illegal, bus.res_ovf);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b required 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    send(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd5, 32'd7);
    checks++;
    if (bus.alu_ctrl !== 4'd2 || bus.alu_a !== 32'd5 || bus.alu_b !== 32'd7) begin
      errors++;
      $display("FAIL add_issue: got ctrl=%0d a=%h b=%h required 2 5 7", bus.alu_ctrl,
               bus.alu_a, bus.alu_b);
    end
    recv(1, "add");
  endtask

  task automatic test_slt();
    send(enc_r(5'd4, 5'd5, 5'd6, 5'd0, 6'h2a), 32'hFFFF_FFFF, 32'd1);
    checks++;
    if (bus.alu_ctrl !== 4'd7 || bus.alu_a !== 32'h7FFF_FFFF || bus.alu_b !== 32'h8000_0001) begin
      errors++;
      $display("FAIL slt_bias: got ctrl=%0d a=%h b=%h required 7 7fffffff 80000001",
               bus.alu_ctrl, bus.alu_a, bus.alu_b);
    end
    recv(1, "slt");
    send(enc_r(5'd4, 5'd5, 5'd6, 5'd0, 6'h2b), 32'hFFFF_FFFF, 32'd1);
    recv(1, "sltu");
    send(enc_i(6'h0a, 5'd4, 5'd7, 16'hFFFE), 32'hFFFF_FFFF, 32'd0);
    recv(1, "slti");
    send(enc_i(6'h0b, 5'd4, 5'd7, 16'hFFFE), 32'h0000_0005, 32'd0);
    recv(1, "sltiu");
  endtask

  task automatic test_branch();
    send(enc_i(6'h04, 5'd8, 5'd9, 16'h0010), 32'h55, 32'h55);
    recv(1, "beq_eq");
    send(enc_i(6'h05, 5'd8, 5'd9, 16'h0010), 32'h55, 32'h55);
    recv(1, "bne_eq");
    send(enc_i(6'h05, 5'd8, 5'd9, 16'h0010), 32'h55, 32'h56);
    recv(1, "bne_ne");
  endtask

  task automatic test_illegal();
    send(enc_i(6'h3f, 5'd1, 5'd2, 16'h1234), 32'd9, 32'd9);
    recv(0, "ill_op");
    send(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h08), 32'd9, 32'd9);
    recv(0, "ill_fn");
  endtask

  task automatic test_mixed();
    send(enc_i(6'h0c, 5'd1, 5'd10, 16'h8F0F), 32'hFFFF_FFFF, 32'd0);
    recv(1, "andi");
    send(enc_i(6'h0d, 5'd1, 5'd11, 16'h8000), 32'h0000_0001, 32'd0);
    recv(1, "ori");
    send(enc_i(6'h09, 5'd1, 5'd12, 16'hFFFF), 32'd10, 32'd0);
    recv(1, "addiu");
    send(enc_r(5'd0, 5'd2, 5'd13, 5'd4, 6'h00), 32'd0, 32'h8000_0F01);
    checks++;
    if (bus.alu_shamt !== 5'd4 || bus.alu_ctrl !== 4'd10) begin
      errors++;
      $display("FAIL sll_issue: got shamt=%0d ctrl=%0d required 4 10", bus.alu_shamt,
               bus.alu_ctrl);
    end
    recv(1, "sll");
    send(enc_r(5'd0, 5'd2, 5'd14, 5'd31, 6'h02), 32'd0, 32'h8000_0000);
    recv(1, "srl");
    send(enc_r(5'd1, 5'd2, 5'd15, 5'd3, 6'h27), 32'h0F0F_0000, 32'h0000_00F0);
    checks++;
    if (bus.alu_shamt !== 5'd0) begin
      errors++;
      $display("FAIL nor_shamt: got %0d required 0", bus.alu_shamt);
    end
    recv(1, "nor");
    send(enc_r(5'd1, 5'd2, 5'd16, 5'd0, 6'h23), 32'd3, 32'd5);
    recv(1, "subu");
    send(enc_r(5'd1, 5'd2, 5'd0, 5'd0, 6'h21), 32'd3, 32'd5);
    recv(1, "addu_r0");
    send(enc_r(5'd1, 5'd2, 5'd17, 5'd0, 6'h25), 32'hA000_0000, 32'h0000_000A);
    recv(1, "or");
  endtask

  task automatic test_stall();
    exp_t e;
    send(enc_r(5'd1, 5'd2, 5'd18, 5'd0, 6'h24), 32'hF0F0_1234, 32'h0FF0_FFFF);
    @(posedge clk);
    #1;
    e = sb_q[0];
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.instr    = enc_r(5'd1, 5'd2, 5'd19, 5'd0, 6'h20);
        bus.in_valid = 1'b1;
      end
      checks++;
      if (bus.res_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.res_data !== e.data ||
          bus.res_wr_reg !== e.wr_reg || bus.res_wr_en !== e.wr_en) begin
        errors++;
        $display("FAIL stall_hold %0d: got v=%b rdy=%b data=%h reg=%0d en=%b required 1 0 %h %0d %b",
                 i, bus.res_valid, bus.in_ready, bus.res_data, bus.res_wr_reg, bus.res_wr_en,
                 e.data, e.wr_reg, e.wr_en);
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    recv(0, "stall_release");
  endtask

  task automatic test_reset_exec();
    send(enc_r(5'd1, 5'd2, 5'd20, 5'd0, 6'h20), 32'd100, 32'd200);
    void'(sb_q.pop_back());
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.res_valid !== 1'b0 || bus.alu_a !== 32'd0) begin
      errors++;
      $display("FAIL rst_exec_during: got rdy=%b v=%b a=%h required 0 0 0", bus.in_ready,
               bus.res_valid, bus.alu_a);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.res_data !== 32'd0) begin
        errors++;
        $display("FAIL rst_exec_after %0d: got rdy=%b v=%b data=%h required 1 0 0", i,
                 bus.in_ready, bus.res_valid, bus.res_data);
      end
      @(posedge clk);
    end
    #1;
  endtask

  task automatic test_back_to_back();
    fork
      begin
        time prev;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
          send(enc_r(5'd1, 5'd2, 5'(21 + i), 5'd0, (i % 2 == 0) ? 6'h21 : 6'h23),
               32'(1000 * (i + 1)), 32'(7 + i));
          if (i > 0) begin
            checks++;
            if (last_acc - prev != 30) begin
              errors++;
              $display("FAIL b2b_rate %0d: got %0t between accepts required 30", i,
                       last_acc - prev);
            end
          end
          prev = last_acc;
        end
      end
      begin
        int   n;
        exp_t e;
        bus.res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
          n = 0;
          while (!bus.res_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
          end
          checks++;
          if (bus.res_valid !== 1'b1 || sb_q.size() == 0) begin
            errors++;
            $display("FAIL b2b_resp %0d: got res_valid=%b queue=%0d required 1 and entry", k,
                     bus.res_valid, sb_q.size());
          end else begin
            e = sb_q.pop_front();
            checks++;
            if (bus.res_data !== e.data || bus.res_wr_reg !== e.wr_reg ||
                bus.res_wr_en !== e.wr_en) begin
              errors++;
              $display("FAIL b2b_data %0d: got %h/%0d/%b required %h/%0d/%b", k, bus.res_data,
                       bus.res_wr_reg, bus.res_wr_en, e.data, e.wr_reg, e.wr_en);
            end
          end
          @(posedge clk);
          #1;
        end
        bus.res_ready = 1'b0;
      end
    join
  endtask

  task automatic test_overflow();
    send(enc_r(5'd1, 5'd2, 5'd25, 5'd0, 6'h20), 32'h7FFF_FFFF, 32'd1);
    recv(1, "add_ovf");
    send(enc_r(5'd1, 5'd2, 5'd25, 5'd0, 6'h21), 32'h7FFF_FFFF, 32'd1);
    recv(1, "addu_wrap");
    send(enc_r(5'd1, 5'd2, 5'd26, 5'd0, 6'h22), 32'h8000_0000, 32'd1);
    recv(1, "sub_ovf");
    send(enc_i(6'h08, 5'd1, 5'd27, 16'h0001), 32'h7FFF_FFFF, 32'd0);
    recv(1, "addi_ovf");
    send(enc_i(6'h08, 5'd1, 5'd27, 16'hFFFF), 32'h7FFF_FFFF, 32'd0);
    recv(1, "addi_ok");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_slt();
    test_branch();
    test_illegal();
    test_mixed();
    test_stall();
    test_reset_exec();
    test_back_to_back();
    test_overflow();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
